// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_pkg
// Purpose : Shared types and constants for the Data_Memory arbiter slice:
//           FSM state encoding, memory geometry, latched request record and
//           the address legality check used at accept time.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package dmem_pkg;

   localparam int unsigned DMEM_DEPTH  = 32;   // words in Data_Memory
   localparam int unsigned DMEM_CYCLES = 2;    // memory command hold cycles
   localparam int unsigned DMEM_ADDR_W = 32;
   localparam int unsigned DMEM_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

   typedef struct packed {
      logic                   write;
      logic [DMEM_ADDR_W-1:0] addr;
      logic [DMEM_DATA_W-1:0] wdata;
   } dmem_req_t;

   // A request is rejected when it falls past the last word or is not
   // word aligned; rejected requests never reach the memory.
   function automatic logic dmem_addr_err(input logic [DMEM_ADDR_W-1:0] addr,
                                          input int unsigned           depth_words);
      logic [DMEM_ADDR_W-1:0] limit;
      limit = DMEM_ADDR_W'(depth_words * 4);
      return (addr >= limit) || (addr[1:0] != 2'b00);
   endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_rr_arbiter
// Purpose : Two-requester round-robin grant, purely combinational.
// Ports   : req_i[1:0]  request vector
//           rr_ptr_i    preferred port when both request
//           en_i        grants allowed this cycle
//           gnt_o[1:0]  one-hot grant (all zero when disabled or no request)
// Rev     : 1.0  initial release
// ============================================================================
module dmem_rr_arbiter (
   input  logic [1:0] req_i,
   input  logic       rr_ptr_i,
   input  logic       en_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = rr_ptr_i ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
         endcase
      end
   end

endmodule : dmem_rr_arbiter
`default_nettype wire

// File: rtl/data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : data_memory_arbiter
// Purpose : Shares single-ported Data_Memory between port 0 (datapath) and
//           port 1 (debug loader). Accepts one request at a time, holds the
//           memory command for MEM_CYCLES cycles, then returns a one-cycle
//           response. Illegal addresses are answered with err and no access.
// Ports   : clk_i, rst_i (async, active-high)
//           rqN_valid_i / rqN_ready_o / rqN_write_i / rqN_addr_i / rqN_wdata_i
//           rsN_valid_o / rsN_err_o / rsN_rdata_o           (N = 0, 1)
//           MemRead_o, MemWrite_o, ReadAddress_o, WriteAddress_o,
//           WriteData_o, ReadData_i                          (memory side)
//           busy_o      high whenever the FSM is not IDLE
// Rev     : 1.0  initial release
// ============================================================================
module data_memory_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W     = DMEM_ADDR_W,
   parameter int unsigned DATA_W     = DMEM_DATA_W,
   parameter int unsigned DEPTH      = DMEM_DEPTH,
   parameter int unsigned MEM_CYCLES = DMEM_CYCLES
) (
   input  logic              clk_i,
   input  logic              rst_i,
   // port 0
   input  logic              rq0_valid_i,
   output logic              rq0_ready_o,
   input  logic              rq0_write_i,
   input  logic [ADDR_W-1:0] rq0_addr_i,
   input  logic [DATA_W-1:0] rq0_wdata_i,
   output logic              rs0_valid_o,
   output logic              rs0_err_o,
   output logic [DATA_W-1:0] rs0_rdata_o,
   // port 1
   input  logic              rq1_valid_i,
   output logic              rq1_ready_o,
   input  logic              rq1_write_i,
   input  logic [ADDR_W-1:0] rq1_addr_i,
   input  logic [DATA_W-1:0] rq1_wdata_i,
   output logic              rs1_valid_o,
   output logic              rs1_err_o,
   output logic [DATA_W-1:0] rs1_rdata_o,
   // memory side
   output logic              MemRead_o,
   output logic              MemWrite_o,
   output logic [ADDR_W-1:0] ReadAddress_o,
   output logic [ADDR_W-1:0] WriteAddress_o,
   output logic [DATA_W-1:0] WriteData_o,
   input  logic [DATA_W-1:0] ReadData_i,
   output logic              busy_o
);

   localparam int unsigned CNT_W = (MEM_CYCLES > 1) ? $clog2(MEM_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_CYCLES - 1);

   dmem_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             rr_ptr_q, rr_ptr_d;
   logic             port_q,  port_d;
   logic             err_q,   err_d;
   dmem_req_t        req_q,   req_d;

   logic [1:0]       gnt;
   logic             arb_en;
   dmem_req_t        sel_req;

   // Grants only in IDLE; reset also masks ready so nothing is offered
   // while the block is held in reset.
   assign arb_en = (state_q == IDLE) && !rst_i;

   dmem_rr_arbiter u_rr_arbiter (
      .req_i    ({rq1_valid_i, rq0_valid_i}),
      .rr_ptr_i (rr_ptr_q),
      .en_i     (arb_en),
      .gnt_o    (gnt)
   );

   assign rq0_ready_o = gnt[0];
   assign rq1_ready_o = gnt[1];

   always_comb begin
      sel_req.write = gnt[1] ? rq1_write_i : rq0_write_i;
      sel_req.addr  = DMEM_ADDR_W'(gnt[1] ? rq1_addr_i  : rq0_addr_i);
      sel_req.wdata = DMEM_DATA_W'(gnt[1] ? rq1_wdata_i : rq0_wdata_i);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rr_ptr_q <= 1'b0;
         port_q   <= 1'b0;
         err_q    <= 1'b0;
         req_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rr_ptr_q <= rr_ptr_d;
         port_q   <= port_d;
         err_q    <= err_d;
         req_q    <= req_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      rr_ptr_d       = rr_ptr_q;
      port_d         = port_q;
      err_d          = err_q;
      req_d          = req_q;

      MemRead_o      = 1'b0;
      MemWrite_o     = 1'b0;
      ReadAddress_o  = '0;
      WriteAddress_o = '0;
      WriteData_o    = '0;
      rs0_valid_o    = 1'b0;
      rs0_err_o      = 1'b0;
      rs0_rdata_o    = '0;
      rs1_valid_o    = 1'b0;
      rs1_err_o      = 1'b0;
      rs1_rdata_o    = '0;
      busy_o         = (state_q != IDLE);

      unique case (state_q)
         IDLE: begin
            if (gnt != 2'b00) begin
               port_d = gnt[1];
               req_d  = sel_req;
               err_d  = dmem_addr_err(sel_req.addr, DEPTH);
               cnt_d  = '0;
               // Illegal requests bypass the memory entirely.
               state_d = err_d ? RESP : CMD;
            end
         end

         CMD: begin
            MemRead_o      = !req_q.write;
            MemWrite_o     = req_q.write;
            ReadAddress_o  = ADDR_W'(req_q.addr);
            WriteAddress_o = ADDR_W'(req_q.addr);
            WriteData_o    = DATA_W'(req_q.wdata);
            if (cnt_q == CNT_LAST) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         RESP: begin
            if (port_q) begin
               rs1_valid_o = 1'b1;
               rs1_err_o   = err_q;
               rs1_rdata_o = (!req_q.write && !err_q) ? ReadData_i : '0;
            end else begin
               rs0_valid_o = 1'b1;
               rs0_err_o   = err_q;
               rs0_rdata_o = (!req_q.write && !err_q) ? ReadData_i : '0;
            end
            rr_ptr_d = ~rr_ptr_q;
            state_d  = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

endmodule : data_memory_arbiter
`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_memory_arbiter
// Purpose : Directed self-checking bench for data_memory_arbiter with a
//           small Data_Memory model (read data registered on MemRead).
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_data_memory_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        rq0_valid, rq0_ready, rq0_write;
   logic [31:0] rq0_addr, rq0_wdata;
   logic        rs0_valid, rs0_err;
   logic [31:0] rs0_rdata;
   logic        rq1_valid, rq1_ready, rq1_write;
   logic [31:0] rq1_addr, rq1_wdata;
   logic        rs1_valid, rs1_err;
   logic [31:0] rs1_rdata;
   logic        MemRead, MemWrite;
   logic [31:0] ReadAddress, WriteAddress, WriteData, ReadData;
   logic        busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   data_memory_arbiter dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .rq0_valid_i    (rq0_valid),
      .rq0_ready_o    (rq0_ready),
      .rq0_write_i    (rq0_write),
      .rq0_addr_i     (rq0_addr),
      .rq0_wdata_i    (rq0_wdata),
      .rs0_valid_o    (rs0_valid),
      .rs0_err_o      (rs0_err),
      .rs0_rdata_o    (rs0_rdata),
      .rq1_valid_i    (rq1_valid),
      .rq1_ready_o    (rq1_ready),
      .rq1_write_i    (rq1_write),
      .rq1_addr_i     (rq1_addr),
      .rq1_wdata_i    (rq1_wdata),
      .rs1_valid_o    (rs1_valid),
      .rs1_err_o      (rs1_err),
      .rs1_rdata_o    (rs1_rdata),
      .MemRead_o      (MemRead),
      .MemWrite_o     (MemWrite),
      .ReadAddress_o  (ReadAddress),
      .WriteAddress_o (WriteAddress),
      .WriteData_o    (WriteData),
      .ReadData_i     (ReadData),
      .busy_o         (busy)
   );

   // Data_Memory model: contents restored on reset, word 1 = 84, word 2 = 11.
   logic [31:0] mem [0:31];
   logic [31:0] rd_q;
   assign ReadData = rd_q;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
         mem[1] <= 32'd84;
         mem[2] <= 32'd11;
         rd_q   <= 32'd0;
      end else begin
         if (MemWrite) mem[WriteAddress[6:2]] <= WriteData;
         if (MemRead)  rd_q <= mem[ReadAddress[6:2]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One isolated transaction, starting mid-cycle in IDLE and ending
   // mid-cycle in the IDLE cycle after the response.
   task automatic do_txn(input string tag, input logic port, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rdata);
      if (port) begin
         rq1_valid = 1'b1; rq1_write = wr; rq1_addr = addr; rq1_wdata = wdata;
      end else begin
         rq0_valid = 1'b1; rq0_write = wr; rq0_addr = addr; rq0_wdata = wdata;
      end
      #1;
      chk({tag, ".ready"}, {31'd0, port ? rq1_ready : rq0_ready}, 32'd1);
      step();
      rq0_valid = 1'b0;
      rq1_valid = 1'b0;
      if (!exp_err) begin
         for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk({tag, ".memread"},  {31'd0, MemRead},  {31'd0, !wr});
            chk({tag, ".memwrite"}, {31'd0, MemWrite}, {31'd0, wr});
            chk({tag, ".raddr"},    ReadAddress,  addr);
            chk({tag, ".waddr"},    WriteAddress, addr);
            chk({tag, ".wdata"},    WriteData,    wdata);
            chk({tag, ".busy"},     {31'd0, busy}, 32'd1);
            step();
         end
      end
      @(negedge clk);
      chk({tag, ".rs_valid"}, {31'd0, port ? rs1_valid : rs0_valid}, 32'd1);
      chk({tag, ".rs_other"}, {31'd0, port ? rs0_valid : rs1_valid}, 32'd0);
      chk({tag, ".rs_err"},   {31'd0, port ? rs1_err : rs0_err}, {31'd0, exp_err});
      chk({tag, ".rs_rdata"}, port ? rs1_rdata : rs0_rdata, exp_rdata);
      chk({tag, ".strobes"},  {30'd0, MemRead, MemWrite}, 32'd0);
      step();
      @(negedge clk);
      chk({tag, ".post_valid"}, {30'd0, rs1_valid, rs0_valid}, 32'd0);
      chk({tag, ".post_busy"},  {31'd0, busy}, 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      rq0_valid = 1'b1; rq0_write = 1'b0; rq0_addr = 32'd4; rq0_wdata = 32'd0;
      rq1_valid = 1'b0; rq1_write = 1'b0; rq1_addr = 32'd0; rq1_wdata = 32'd0;

      // Reset: everything quiet, even with a valid request pending.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.ready0",  {31'd0, rq0_ready}, 32'd0);
      chk("rst.busy",    {31'd0, busy}, 32'd0);
      chk("rst.strobes", {30'd0, MemRead, MemWrite}, 32'd0);
      chk("rst.raddr",   ReadAddress, 32'd0);
      chk("rst.rs",      {30'd0, rs1_valid, rs0_valid}, 32'd0);
      rq0_valid = 1'b0;
      rst = 1'b0;
      step();
      @(negedge clk);

      // Single load from addr 4.
      do_txn("load4", 1'b0, 1'b0, 32'd4, 32'd0, 1'b0, 32'd84);
      // Store then load on port 1.
      do_txn("store12", 1'b1, 1'b1, 32'd12, 32'hDEADBEEF, 1'b0, 32'd0);
      do_txn("load12",  1'b1, 1'b0, 32'd12, 32'd0,        1'b0, 32'hDEADBEEF);
      // Error responses: out of range and misaligned.
      do_txn("err128", 1'b0, 1'b0, 32'd128, 32'd0, 1'b1, 32'd0);
      do_txn("err6",   1'b0, 1'b0, 32'd6,   32'd0, 1'b1, 32'd0);

      // Reset during the second MemWrite cycle.
      rq0_valid = 1'b1; rq0_write = 1'b1; rq0_addr = 32'd16; rq0_wdata = 32'h12345678;
      #1;
      chk("abort.ready", {31'd0, rq0_ready}, 32'd1);
      step();
      rq0_valid = 1'b0;
      @(negedge clk);
      chk("abort.wr1", {31'd0, MemWrite}, 32'd1);
      step();
      @(negedge clk);
      chk("abort.wr2", {31'd0, MemWrite}, 32'd1);
      rst = 1'b1;
      #1;
      chk("abort.memwrite", {31'd0, MemWrite}, 32'd0);
      chk("abort.busy",     {31'd0, busy}, 32'd0);
      chk("abort.waddr",    WriteAddress, 32'd0);
      chk("abort.wdata",    WriteData, 32'd0);
      step();
      chk("abort.rs", {30'd0, rs1_valid, rs0_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;

      // Contention after reset: rr_ptr starts at 0, grants alternate.
      rq0_valid = 1'b1; rq0_write = 1'b0; rq0_addr = 32'd4;
      rq1_valid = 1'b1; rq1_write = 1'b0; rq1_addr = 32'd8;
      for (int k = 0; k < 4; k++) begin
         if (k != 0) @(negedge clk);
         else #1;
         chk($sformatf("cont%0d.ready", k), {30'd0, rq1_ready, rq0_ready},
             (k % 2 == 0) ? 32'd1 : 32'd2);
         step();
         step();
         step();
         @(negedge clk);
         chk($sformatf("cont%0d.rsv", k), {30'd0, rs1_valid, rs0_valid},
             (k % 2 == 0) ? 32'd1 : 32'd2);
         chk($sformatf("cont%0d.rdata", k), (k % 2 == 0) ? rs0_rdata : rs1_rdata,
             (k % 2 == 0) ? 32'd84 : 32'd11);
         step();
      end
      rq0_valid = 1'b0;
      rq1_valid = 1'b0;

      // Idle hold.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle.ctl", {27'd0, busy, rq0_ready, rq1_ready, MemRead, MemWrite}, 32'd0);
         chk("idle.addr", ReadAddress | WriteAddress, 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_data_memory_arbiter
`default_nettype wire
